// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester streams plus the FIFO write port shared
// between the requesters and fifo_wr_arbiter.
//   master : the environment (requesters drive valid/data/last, the FIFO
//            drives full).
//   slave  : the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int REQ_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wr_data;
    logic [REQ_W-1:0]         grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NUM_REQ valid/ready requesters. A grant is held for a burst that ends on
// req_last or after MAX_BURST beats; the next owner is picked in the same
// cycle, so back-to-back bursts have no bubble.
// Optional feature: define ARB_TIMEOUT_EN to release a grant whose owner has
// been idle (valid low, FIFO not full) for TIMEOUT cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int REQ_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2) begin : g_chk_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_chk_max_burst
        $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("fifo_wr_arbiter: TIMEOUT must be >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [REQ_W-1:0] grant_id, grant_nx;
    logic [REQ_W-1:0] rr_ptr, rr_nx;
    logic [CNT_W-1:0] beat_cnt, beat_nx;

    logic             any_valid;
    logic [REQ_W-1:0] pick;
    logic             beat;
    logic             burst_end;
    logic             release_g;
    logic [WIDTH-1:0] owner_data;

`ifdef ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt, idle_nx;
    logic              owner_idle;
    logic              timed_out;
`endif

    // First set bit of vec searching ptr+1, ptr+2, ... modulo NUM_REQ; ptr
    // itself is checked last. Returns ptr when vec is empty (caller gates).
    function automatic logic [REQ_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                                 input logic [REQ_W-1:0]   ptr);
        logic [REQ_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && vec[REQ_W'(idx)]) begin
                sel   = REQ_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Beat qualification, burst-end detection and the owner's data slice.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        any_valid  = |bus.req_valid;
        // In GRANT rr_ptr equals grant_id, so the owner is searched last and
        // is only re-picked when no other requester is valid.
        pick       = rr_pick(bus.req_valid, rr_ptr);
        beat       = (state == GRANT) && bus.req_valid[grant_id] && !bus.fifo_full;
        burst_end  = beat && (bus.req_last[grant_id] ||
                              (beat_cnt == CNT_W'(MAX_BURST - 1)));
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((state == GRANT) && (grant_id == REQ_W'(k))) begin
                owner_data = bus.req_data[k*WIDTH +: WIDTH];
            end
        end
`ifdef ARB_TIMEOUT_EN
        owner_idle = (state == GRANT) && !bus.req_valid[grant_id] && !bus.fifo_full;
        timed_out  = owner_idle && (idle_cnt == IDLE_W'(TIMEOUT - 1));
        release_g  = burst_end || timed_out;
`else
        release_g  = burst_end;
`endif
    end

    // Drive the shared write port and the per-requester ready.
    always_comb begin
        bus.fifo_wr_en   = beat;
        bus.fifo_wr_data = owner_data;
        bus.req_ready    = beat ? (NUM_REQ'(1) << grant_id) : '0;
        bus.grant_id     = grant_id;
        bus.busy         = (state == GRANT);
    end

    // Next-state logic: arbitration from IDLE, beat counting, and the
    // same-cycle hand-over to the next owner on release.
    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        beat_nx  = beat_cnt;
`ifdef ARB_TIMEOUT_EN
        idle_nx  = idle_cnt;
`endif
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nx = GRANT;
                    grant_nx = pick;
                    rr_nx    = pick;
                    beat_nx  = '0;
`ifdef ARB_TIMEOUT_EN
                    idle_nx  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_g) begin
                    if (any_valid) begin
                        grant_nx = pick;
                        rr_nx    = pick;
                    end else begin
                        state_nx = IDLE;
                    end
                    beat_nx = '0;
`ifdef ARB_TIMEOUT_EN
                    idle_nx = '0;
`endif
                end else if (beat) begin
                    beat_nx = beat_cnt + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
                    idle_nx = '0;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (owner_idle) begin
                    idle_nx = idle_cnt + IDLE_W'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= REQ_W'(NUM_REQ - 1);
            beat_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            grant_id <= grant_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= beat_nx;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= idle_nx;
`endif
        end
    end
endmodule
